// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the UART instruction-memory
//                loader (loader/receiver state encodings, default sync byte).
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

   // Loader frame-parsing states
   typedef enum logic [2:0] {
      WAIT_SYNC = 3'd0,
      GET_COUNT = 3'd1,
      GET_DATA  = 3'd2,
      CHECK     = 3'd3,
      DONE      = 3'd4,
      ERROR     = 3'd5
   } loader_state_t;

   // UART bit-level receiver states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0] C_DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver. Two-flop synchronizer followed by a
//                bit FSM sampling mid-bit. Emits a one-cycle rx_valid with
//                rx_byte on a good stop bit, or a one-cycle rx_ferr on a bad
//                stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_byte
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 521
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int                 C_CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);

   logic               r_sync1;
   logic               r_sync2;
   rx_state_t          r_state;
   rx_state_t          w_next;
   logic [C_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               w_cnt_clr;
   logic               w_shift_en;

   // Bring the asynchronous serial line into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_in;
         r_sync2 <= r_sync1;
      end
   end

   // Bit FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Bit FSM next state, sample points and byte/framing-error pulses
   always_comb begin
      w_next     = r_state;
      w_cnt_clr  = 1'b0;
      w_shift_en = 1'b0;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_clr = 1'b1;
            if (!r_sync2) w_next = START;
         end
         START: begin
            if (r_cnt == C_HALF_LAST) begin
               w_cnt_clr = 1'b1;
               w_next    = r_sync2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == C_BIT_LAST) begin
               w_cnt_clr  = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) w_next = STOP;
            end
         end
         STOP: begin
            if (r_cnt == C_BIT_LAST) begin
               w_cnt_clr = 1'b1;
               rx_valid  = r_sync2;
               rx_ferr   = ~r_sync2;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Bit timer, bit index and LSB-first shift register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
         if (r_state == START) r_bit_idx <= 3'd0;
         if (w_shift_en) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

   assign rx_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_uart_loader
//  Description : Loads a framed program image (sync, count, 4*N big-endian
//                data bytes) from a UART line into instruction memory and
//                holds the CPU until the image is complete.
//                Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing
//                modulo-256 checksum byte verified in state CHECK.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 521,
   parameter int         WADDR_W      = 5,
   parameter logic [7:0] SYNC_BYTE    = C_DEFAULT_SYNC_BYTE
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_in,
   input  logic               rearm,
   output logic               imem_we,
   output logic [WADDR_W-1:0] imem_waddr,
   output logic [31:0]        imem_wdata,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_error,
   output logic [WADDR_W:0]   words_loaded
);

   localparam logic [31:0] C_MAX_WORDS = 32'd1 << WADDR_W;

   logic [7:0]         w_rx_byte;
   logic               w_rx_valid;
   logic               w_rx_ferr;
   loader_state_t      r_state;
   loader_state_t      w_next;
   logic               r_rearm_d1;
   logic               r_rearm_d2;
   logic               w_rearm_edge;
   logic               w_count_ok;
   logic               w_words_full;
   logic [WADDR_W:0]   r_count;
   logic [WADDR_W:0]   r_words;
   logic [1:0]         r_byte_idx;
   logic [23:0]        r_word;
   logic               r_we;
   logic [WADDR_W-1:0] r_waddr;
   logic [31:0]        r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         r_sum;
`endif

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx_in    (rx_in),
      .rx_byte  (w_rx_byte),
      .rx_valid (w_rx_valid),
      .rx_ferr  (w_rx_ferr)
   );

   assign w_count_ok   = (w_rx_byte != 8'd0) && ({24'd0, w_rx_byte} <= C_MAX_WORDS);
   assign w_words_full = (r_words == r_count);
   assign w_rearm_edge = r_rearm_d1 & ~r_rearm_d2;

   // Register rearm so only its rising edge is acted upon
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rearm_d1 <= 1'b0;
         r_rearm_d2 <= 1'b0;
      end else begin
         r_rearm_d1 <= rearm;
         r_rearm_d2 <= r_rearm_d1;
      end
   end

   // Loader FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= WAIT_SYNC;
      else        r_state <= w_next;
   end

   // Loader FSM next state; leaves GET_DATA only after the final write strobe
   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT_SYNC: if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) w_next = GET_COUNT;
         GET_COUNT: begin
            if (w_rx_ferr)       w_next = ERROR;
            else if (w_rx_valid) w_next = w_count_ok ? GET_DATA : ERROR;
         end
         GET_DATA: begin
            if (w_rx_ferr) w_next = ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else if (w_words_full) w_next = CHECK;
`else
            else if (w_words_full) w_next = DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (w_rx_ferr)       w_next = ERROR;
            else if (w_rx_valid) w_next = (w_rx_byte == r_sum) ? DONE : ERROR;
         end
`endif
         DONE:    if (w_rearm_edge) w_next = WAIT_SYNC;
         ERROR:   if (w_rearm_edge) w_next = WAIT_SYNC;
         default: w_next = ERROR;
      endcase
   end

   // Word assembly, write strobe and word counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_words    <= '0;
         r_byte_idx <= 2'd0;
         r_word     <= 24'd0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_sum      <= 8'd0;
`endif
      end else begin
         r_we <= 1'b0;
         if ((r_state == GET_COUNT) && w_rx_valid && w_count_ok) begin
            r_count    <= (WADDR_W+1)'(w_rx_byte);
            r_words    <= '0;
            r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
         end
         if ((r_state == GET_DATA) && w_rx_valid && !w_words_full) begin
            r_word     <= {r_word[15:0], w_rx_byte};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + w_rx_byte;
`endif
            if (r_byte_idx == 2'd3) begin
               r_we    <= 1'b1;
               r_waddr <= r_words[WADDR_W-1:0];
               r_wdata <= {r_word, w_rx_byte};
               r_words <= r_words + 1'b1;
            end
         end
      end
   end

   assign imem_we      = r_we;
   assign imem_waddr   = r_waddr;
   assign imem_wdata   = r_wdata;
   assign words_loaded = r_words;
   assign load_done    = (r_state == DONE);
   assign load_error   = (r_state == ERROR);
   assign cpu_hold     = (r_state != DONE);

endmodule
`default_nettype wire

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Serial program loader: the writer side for the instruction memory that the pipeline's fetch stage reads.
- Receives a framed program image over an 8N1 UART line and assembles big-endian 32-bit words.
- Issues single-cycle write strobes to the instruction-memory write port.
- Holds the processor (cpu_hold) until a complete, valid image has been written.

Parameters:
- CLKS_PER_BIT, 521, clk cycles per UART bit (5 MHz / 9600 baud); minimum 4.
- WADDR_W, 5, instruction-memory word-address width (32 words, matching the 7-bit byte PC).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  UART serial input, idle high, asynchronous to clk.
- rearm  input  1  level; a registered rising edge returns the loader from DONE/ERROR to WAIT_SYNC.
- imem_we  output  1  one-cycle write strobe.
- imem_waddr  output  WADDR_W  word address for the write.
- imem_wdata  output  32  word data for the write.
- cpu_hold  output  1  high = processor must be kept frozen.
- load_done  output  1  image fully written and accepted.
- load_error  output  1  frame, count or checksum error latched.
- words_loaded  output  WADDR_W+1  number of words written so far.

Behaviour:
- Reset values: imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0, state=WAIT_SYNC, receiver IDLE.
- Reset asserted mid-frame aborts immediately; the partial image is not erased.
- Receiver:
  - rx_in passes through a 2-flop synchronizer, then the bit FSM IDLE -> START -> DATA -> STOP.
  - IDLE: a synchronized low moves to START.
  - START: sample at CLKS_PER_BIT/2 (integer division). Still low -> DATA; high -> glitch, back to IDLE, no byte.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits.
  - STOP: sample after CLKS_PER_BIT. A 1 gives a one-cycle rx_valid with rx_byte. A 0 gives a one-cycle rx_ferr and no rx_valid. Either way return to IDLE.
- Loader FSM (advances only on rx_valid/rx_ferr pulses):
  - WAIT_SYNC: byte == SYNC_BYTE -> GET_COUNT; any other byte is ignored; rx_ferr is ignored.
  - GET_COUNT: byte N with 1 <= N <= 2^WADDR_W -> latch N, clear words_loaded and the byte index, go to GET_DATA. N=0 or N>2^WADDR_W -> ERROR.
  - GET_DATA: shift the byte into the word register, first byte into [31:24]. On the 4th byte, the next cycle drives imem_we=1 with imem_waddr=words_loaded[WADDR_W-1:0] and the assembled imem_wdata, and words_loaded increments in that same cycle. When words_loaded reaches N after the write -> DONE (or CHECK when CHECKSUM_EN is defined).
  - DONE: load_done=1, cpu_hold=0; received bytes are ignored.
  - ERROR: load_error=1, cpu_hold=1; bytes are ignored.
  - rx_ferr in GET_COUNT, GET_DATA or CHECK -> ERROR.
  - A rearm rising edge in DONE or ERROR -> WAIT_SYNC, clears load_done/load_error, cpu_hold=1. A rearm edge in any other state is ignored.
- Timing and output rules:
  - Latency from the stop-bit sample of the 4th byte to imem_we is exactly 1 cycle.
  - imem_waddr and imem_wdata hold their last values between strobes.
  - imem_we never asserts outside GET_DATA.
  - cpu_hold is high in every state except DONE; load_done and cpu_hold change in the same cycle.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CHECK after the last word.
  - The next byte must equal the 8-bit modulo-256 sum of all 4N data bytes (header and count excluded).
  - Match -> DONE; mismatch -> ERROR.
  - An internal 8-bit accumulator clears on entry to GET_DATA.
- Not defined: no CHECK state and no accumulator; GET_DATA goes directly to DONE.

Decomposition:
- Package imem_loader_pkg:
  - loader state enum (WAIT_SYNC, GET_COUNT, GET_DATA, CHECK, DONE, ERROR);
  - receiver state enum (IDLE, START, DATA, STOP);
  - default SYNC_BYTE constant.
- One sub-module, uart_rx_byte (synchronizer plus bit FSM, parameter CLKS_PER_BIT; outputs rx_byte, rx_valid, rx_ferr). The top holds the loader FSM and the word assembly.

Test Plan:
- CLKS_PER_BIT=8; after reset send A5,02,12,34,56,78,DE,AD,BE,EF -> imem_we pulses twice: addr 0 with 32'h12345678, addr 1 with 32'hDEADBEEF. Then load_done=1, cpu_hold=0, words_loaded=2.
- Send 00,FF,A5,01,00,00,00,2A -> the leading bytes are ignored; one write, addr 0 with 32'h0000002A; DONE.
- Send A5,00 -> ERROR, load_error=1, cpu_hold=1, no imem_we. Pulse rearm, then send A5,01,11,22,33,44 -> addr 0 with 32'h11223344, load_done=1.
- Send A5,02,AA then a byte with stop bit 0 -> ERROR, no imem_we. A 2-cycle low glitch on an idle rx_in produces no byte.
- Assert reset mid-way through the 3rd data byte -> all outputs return to reset values within the same cycle; a subsequent full frame loads correctly.
- With IMEM_LOADER_CHECKSUM_EN: A5,01,01,02,03,04,0A -> DONE. Same frame ending 0B -> ERROR, with the single word already written at addr 0.
